sub_b_vec_drv: RTL and testbench
================================

# sub_b_vec_drv

Self-checking stimulus stage that sits directly upstream of `sub_b`. It drives `sub_b`'s three single-bit inputs with a deterministic vector sweep after a start pulse. It captures `sub_b`'s three outputs a fixed number of cycles later and compacts them into a 16-bit MISR signature. A run ends with a one-cycle done pulse; the signature is then compared against a golden value.

## Interface
- `NUM_VEC`, default 16: vectors per run; legal range 1..255.
- `CAP_LAT`, default 1: edges between a vector being registered and its response being sampled; legal range 1..4.
- `POLY`, default 16'h1021: MISR feedback polynomial.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk`.
- `start_b`  in  1  run request; honoured only in IDLE.
- `testi1_b`, `testi2_b`, `testi3_b`  out  1 each  vector bits 0, 1, 2 to `sub_b`.
- `testo1_b`, `testo2_b`, `testo1_sub_b_rename`  in  1 each  `sub_b` responses (MISR bits 0, 1, 2).
- `busy_b`  out  1  run in progress.
- `done_b`  out  1  one-cycle end-of-run pulse.
- `sig_b`  out  16  MISR signature; holds between runs.
- `vec_cnt_b`  out  8  responses captured in the current or last run.

## Operation
- **Reset:** `rst_n` is low at an edge.
  - State goes to IDLE.
  - All outputs go to 0: `testi*_b`, `busy_b`, `done_b`, `sig_b`, `vec_cnt_b`.
  - The capture pipeline is cleared.
- **IDLE:** `start_b`=1 at an edge causes:
  - `sig_b` and `vec_cnt_b` cleared to 0.
  - Drive index cleared to 0.
  - Move to RUN.
- **RUN:** each edge registers vector k onto `testi*_b`, with {testi3,testi2,testi1} = k[2:0] (sweep 0..7, wraps). A valid token enters a CAP_LAT-deep shift register. When k = NUM_VEC-1 has been registered, move to DRAIN.
- **DRAIN:** `testi*_b` are driven 0. The FSM waits until the last token exits the shift register, then moves to DONE.
- **Capture:** at any edge where a token exits the shift register:
  - r = {testo1_sub_b_rename, testo2_b, testo1_b}.
  - sig_b ← (sig_b<<1) ^ (sig_b[15] ? POLY : 0) ^ {13'b0, r}.
  - vec_cnt_b increments.
- **DONE:** lasts exactly one cycle, with `done_b`=1, `busy_b`=0 and `testi*_b`=0. The FSM then returns to IDLE.
- **`busy_b`:** 1 in RUN and DRAIN only.
- **Boundary conditions:**
  - `start_b` in RUN, DRAIN or DONE is ignored, with no restart and no queuing.
  - `start_b` held high re-launches at the first IDLE edge after DONE.
  - Reset mid-run aborts immediately with the full reset values. Partial signatures are discarded.
  - When CAP_LAT=1 and NUM_VEC=1, the FSM passes straight RUN→DRAIN→DONE.
  - `vec_cnt_b` never exceeds NUM_VEC.

## Timing
Edge 0 is the edge where `start_b` is sampled in IDLE.

- **Vector k:** visible from edge 1+k and held for one cycle.
- **Response k:** sampled at edge 1+k+CAP_LAT.
  - With CAP_LAT=1 this is the edge ending vector k's cycle, which suits a combinational `sub_b`.
  - Larger CAP_LAT values suit registered downstream paths.
- **Last capture:** edge NUM_VEC+CAP_LAT.
- **End of run:** after the last-capture edge, `busy_b`=0 and `done_b`=1. `sig_b` and `vec_cnt_b` already hold their final values.
- **Next start:** `done_b` drops at the following edge. The earliest accepted next `start_b` is at edge NUM_VEC+CAP_LAT+2.
- **Start-to-done latency:** NUM_VEC+CAP_LAT edges.
- No combinational path from any input to any output.

## Test plan
- **Reset values:** hold `rst_n`=0 for 3 edges, then release → all outputs 0. `start_b` pulsed in the same cycle as the `rst_n` release is not honoured.
- **Default sweep, responses tied 0:** defaults, one `start_b` pulse →
  - `testi*_b` sequence 0,1,…,7,0,…,7 on edges 1..16.
  - `busy_b` high after edges 1..16.
  - `done_b` high only after edge 17.
  - `sig_b`=16'h0000, `vec_cnt_b`=16.
- **Signature arithmetic:** NUM_VEC=2, `testo1_b` tied 1, others 0 → `sig_b`=16'h0001 after edge 2 and 16'h0003 at `done_b`. Then NUM_VEC=17 with all responses tied 1 → `sig_b` matches the bench MISR model and the POLY feedback is exercised.
- **Ignored starts:** `start_b` pulses at edges 4, 10 and during the DONE cycle → a single run, `done_b` once at edge 17 (+1 cycle), `vec_cnt_b`=16.
- **Reset mid-run:** `rst_n`=0 at edge 6 →
  - Next cycle: `busy_b`=0, `testi*_b`=0, `sig_b`=0, `vec_cnt_b`=0, no `done_b`.
  - A fresh start then completes normally.
- **Capture latency:** CAP_LAT=3, bench delays a loopback response ({testi3,testi2,testi1}) by 3 edges →
  - Capture k occurs at edge 4+k.
  - `done_b` follows edge 19.
  - `sig_b` equals the bench model.
  - A 2-edge delay yields a mismatching signature.

Source files
------------

// File: rtl/sub_b_vec_drv.sv
// sub_b_vec_drv: sweeps a 3-bit vector into sub_b after a start pulse,
// captures sub_b's 3-bit response CAP_LAT edges later and folds it into a
// 16-bit MISR signature. A run ends with a one-cycle done_b pulse.
module sub_b_vec_drv #(
    parameter int          NUM_VEC = 16,
    parameter int          CAP_LAT = 1,
    parameter logic [15:0] POLY    = 16'h1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_b,
    output logic        testi1_b,
    output logic        testi2_b,
    output logic        testi3_b,
    input  logic        testo1_b,
    input  logic        testo2_b,
    input  logic        testo1_sub_b_rename,
    output logic        busy_b,
    output logic        done_b,
    output logic [15:0] sig_b,
    output logic [7:0]  vec_cnt_b
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Index of the final vector; also the capture count just before the last capture
    localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);

    logic [1:0]         state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic [2:0]         testi_q, testi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        sig_q, sig_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [CAP_LAT-1:0] tok_q, tok_d;

    logic               push;
    logic               cap;
    logic [2:0]         resp;

    // A token leaving the last stage marks the edge at which the response is sampled
    assign cap  = tok_q[CAP_LAT-1];
    assign resp = {testo1_sub_b_rename, testo2_b, testo1_b};

    // Valid-token shift register: one token per registered vector, CAP_LAT stages deep
    always_comb begin
        tok_d    = '0;
        tok_d[0] = push;
        for (int i = 1; i < CAP_LAT; i++) begin
            tok_d[i] = tok_q[i-1];
        end
    end

    // Run-control FSM, vector generation and MISR compaction
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        testi_d = 3'b000;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        push    = 1'b0;

        if (cap) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {13'b0, resp};
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_b) begin
                    sig_d   = 16'h0000;
                    cnt_d   = 8'd0;
                    idx_d   = 8'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                testi_d = idx_q[2:0];
                push    = 1'b1;
                idx_d   = idx_q + 8'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last token leaves exactly when the final capture happens
                if (cap && (cnt_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'd0;
            testi_q <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= 16'h0000;
            cnt_q   <= 8'd0;
            tok_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            testi_q <= testi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            tok_q   <= tok_d;
        end
    end

    assign testi1_b  = testi_q[0];
    assign testi2_b  = testi_q[1];
    assign testi3_b  = testi_q[2];
    assign busy_b    = busy_q;
    assign done_b    = done_q;
    assign sig_b     = sig_q;
    assign vec_cnt_b = cnt_q;

endmodule

// File: tb/tb_sub_b_vec_drv.sv
// Testbench for sub_b_vec_drv: four instances with different NUM_VEC/CAP_LAT,
// a scoreboard queue of expected end-of-run results and a done_b monitor.
module tb_sub_b_vec_drv;

    localparam int          NV [4] = '{16, 2, 17, 16};
    localparam int          CL [4] = '{1, 1, 1, 3};
    localparam logic [15:0] POLY   = 16'h1021;

    typedef struct packed {
        logic [1:0]  inst;
        logic        neq;
        logic [15:0] sig;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [4];
    logic [2:0]  resp_drv [4];
    wire  [2:0]  resp_in [4];
    wire  [2:0]  vec [4];
    wire         busy [4];
    wire         done [4];
    wire  [15:0] sig [4];
    wire  [7:0]  cnt [4];

    logic [2:0]  dl [2];
    logic        loop_en;
    int          loop_d;
    logic [2:0]  rnd [64];

    exp_t        sb_q [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // Loopback delay line used by instance 3: response = vector delayed loop_d edges
    always @(posedge clk) begin
        dl[0] <= vec[3];
        dl[1] <= dl[0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            if (gi == 3) begin : g_loop
                assign resp_in[gi] = loop_en ? ((loop_d == 3) ? dl[1] : dl[0]) : resp_drv[gi];
            end else begin : g_plain
                assign resp_in[gi] = resp_drv[gi];
            end
            sub_b_vec_drv #(.NUM_VEC(NV[gi]), .CAP_LAT(CL[gi]), .POLY(POLY)) u_dut (
                .clk                 (clk),
                .rst_n               (rst_n),
                .start_b             (start[gi]),
                .testi1_b            (vec[gi][0]),
                .testi2_b            (vec[gi][1]),
                .testi3_b            (vec[gi][2]),
                .testo1_b            (resp_in[gi][0]),
                .testo2_b            (resp_in[gi][1]),
                .testo1_sub_b_rename (resp_in[gi][2]),
                .busy_b              (busy[gi]),
                .done_b              (done[gi]),
                .sig_b               (sig[gi]),
                .vec_cnt_b           (cnt[gi])
            );
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [2:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {13'b0, r};
    endfunction

    task automatic check_zero(input int i, input string name);
        check(name, {3'b0, vec[i], busy[i], done[i], sig[i], cnt[i]}, 32'h0);
    endtask

    // Monitor: every done_b pulse pops one expected result and compares it
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (done[i] === 1'b1) begin
                $display("run end: inst=%0d sig=%h vec_cnt=%0d", i, sig[i], cnt[i]);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: inst %0d pulsed done_b, required no run end", i);
                end else begin
                    e = sb_q.pop_front();
                    check("done_inst", i, 32'(e.inst));
                    if (e.neq) begin
                        checks++;
                        if (sig[i] === e.sig) begin
                            errors++;
                            $display("FAIL sig_differs: got %h, required a value other than %h", sig[i], e.sig);
                        end
                    end else begin
                        check("sig", 32'(sig[i]), 32'(e.sig));
                    end
                    check("vec_cnt", 32'(cnt[i]), 32'(e.cnt));
                end
            end
        end
    end

    // One complete run on instance i. mode 0: responses from rnd[] (value
    // driven during the cycle after edge e is rnd[e]); mode 1: loopback.
    task automatic launch(input int i, input int mode, input bit ign, input bit neq);
        int          n;
        int          c;
        logic [15:0] s;
        logic [2:0]  r;
        logic [2:0]  r0;
        exp_t        e;
        n  = NV[i];
        c  = CL[i];
        s  = 16'h0000;
        r0 = 3'b000;
        for (int k = 0; k < n; k++) begin
            r = (mode == 0) ? rnd[k + c] : 3'(k % 8);
            if (k == 0) r0 = r;
            s = misr(s, r);
        end
        e.inst = 2'(i);
        e.neq  = neq;
        e.sig  = s;
        e.cnt  = 8'(n);
        sb_q.push_back(e);

        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        if (mode == 0) resp_drv[i] = rnd[0];
        for (int ed = 1; ed <= n + c + 1; ed++) begin
            if (ign && (ed == 4 || ed == 10 || ed == n + c + 1)) start[i] = 1'b1;
            tick();
            start[i] = 1'b0;
            if (mode == 0) resp_drv[i] = rnd[ed];
            if (ed <= n) check("vec", 32'(vec[i]), 32'((ed - 1) % 8));
            else         check("vec_idle", 32'(vec[i]), 32'h0);
            check("busy", 32'(busy[i]), (ed < n + c) ? 32'h1 : 32'h0);
            check("done", 32'(done[i]), (ed == n + c) ? 32'h1 : 32'h0);
            if (ed == 1 + c && !neq) begin
                check("sig_first", 32'(sig[i]), {29'b0, r0});
                check("cnt_first", 32'(cnt[i]), 32'h1);
            end
        end
        if (ign) begin
            tick();
            check("busy_after_ign", 32'(busy[i]), 32'h0);
        end
    endtask

    initial begin
        exp_t e;
        rst_n   = 1'b0;
        loop_en = 1'b0;
        loop_d  = 3;
        for (int i = 0; i < 4; i++) begin
            start[i]    = 1'b0;
            resp_drv[i] = 3'b000;
        end

        // Reset for 3 edges; start pulsed during the last reset cycle is ignored
        tick();
        tick();
        start[0] = 1'b1;
        tick();
        rst_n    = 1'b1;
        start[0] = 1'b0;
        for (int i = 0; i < 4; i++) check_zero(i, "reset_vals");
        tick();
        check("no_start_at_release", 32'(busy[0]), 32'h0);

        // Default sweep with responses tied 0
        for (int j = 0; j < 64; j++) rnd[j] = 3'b000;
        launch(0, 0, 1'b0, 1'b0);
        tick();

        // NUM_VEC=2, testo1_b tied 1: signature 1 then 3
        for (int j = 0; j < 64; j++) rnd[j] = 3'b001;
        launch(1, 0, 1'b0, 1'b0);
        tick();

        // NUM_VEC=17, all responses 1: MISR feedback exercised
        for (int j = 0; j < 64; j++) rnd[j] = 3'b111;
        launch(2, 0, 1'b0, 1'b0);
        tick();

        // Random responses with starts at edges 4, 10 and in the DONE cycle
        for (int j = 0; j < 64; j++) rnd[j] = 3'($urandom);
        launch(0, 0, 1'b1, 1'b0);
        tick();

        // start_b held high relaunches at the first IDLE edge after DONE
        resp_drv[1] = 3'b001;
        e.inst = 2'd1;
        e.neq  = 1'b0;
        e.sig  = 16'h0003;
        e.cnt  = 8'd2;
        sb_q.push_back(e);
        sb_q.push_back(e);
        start[1] = 1'b1;
        tick();
        for (int ed = 1; ed <= 8; ed++) begin
            tick();
            if (ed == 4) check("held_idle_gap", 32'(busy[1]), 32'h0);
            if (ed == 5) begin
                check("held_relaunch", 32'(busy[1]), 32'h1);
                start[1] = 1'b0;
            end
        end
        tick();
        tick();

        // Reset at edge 6 of a run aborts it; a fresh run then completes
        for (int j = 0; j < 64; j++) rnd[j] = 3'($urandom);
        resp_drv[0] = 3'b101;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int ed = 1; ed <= 5; ed++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero(0, "midrun_reset");
        tick();
        check("midrun_idle", 32'(busy[0]), 32'h0);
        launch(0, 0, 1'b0, 1'b0);
        tick();

        // CAP_LAT=3 with a matching 3-edge loopback
        loop_en = 1'b1;
        loop_d  = 3;
        launch(3, 1, 1'b0, 1'b0);
        tick();
        tick();

        // Same loopback shortened to 2 edges: signature must not match
        loop_d = 2;
        launch(3, 1, 1'b0, 1'b1);
        tick();
        tick();
        loop_en = 1'b0;

        for (int ed = 0; ed < 5; ed++) tick();
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
